// File: rtl/helppll_ctrl_pkg.sv
// helppll_ctrl_pkg: state encoding and abs/saturate helpers for the helper-PLL loop controller
package helppll_ctrl_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, COARSE = 3'd1, FINE = 3'd2, LOCKED = 3'd3} state_e;
  function automatic logic signed [63:0] abs_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] mn;
    mn = -(64'sd1 <<< (w - 1));
    return (v == mn) ? -(mn + 64'sd1) : ((v < 0) ? -v : v);
  endfunction
  function automatic logic signed [63:0] sat_u(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx;
    mx = (64'sd1 <<< w) - 64'sd1;
    return (v < 0) ? 64'sd0 : ((v > mx) ? mx : v);
  endfunction
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    return (v > mx) ? mx : ((v < -mx - 64'sd1) ? -mx - 64'sd1 : v);
  endfunction
endpackage

// File: rtl/helppll_ctrl_step.sv
// helppll_ctrl_step: registered err -> step -> saturated tune_next (integrator under HELPPLL_CTRL_INTEG_EN)
module helppll_ctrl_step
  import helppll_ctrl_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int TWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              clr_integ,
  input  logic [DWIDTH-1:0] freqdiff,
  input  logic [3:0]        kp_shift,
  input  logic [3:0]        ki_shift,
  input  logic [TWIDTH-1:0] tune,
  output logic              valid,
  output logic [DWIDTH-1:0] abs_err,
  output logic [TWIDTH-1:0] tune_next
);
  logic signed [DWIDTH-1:0] err_q, err_d;
  logic valid_q, valid_d;
  logic signed [63:0] step_raw, step;
  always_comb begin
    err_d = accept ? $signed(freqdiff) : err_q;
    valid_d = accept;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
      valid_q <= 1'b0;
    end else begin
      err_q <= err_d;
      valid_q <= valid_d;
    end
  end
`ifdef HELPPLL_CTRL_INTEG_EN
  localparam int IW = DWIDTH + 8;
  logic signed [IW-1:0] integ_q, integ_d;
  always_comb integ_d = clr_integ ? '0 : accept ? IW'(sat_s(64'(integ_q) + 64'($signed(freqdiff)), IW)) : integ_q;
  always_ff @(posedge clk) begin
    if (reset) integ_q <= '0;
    else integ_q <= integ_d;
  end
  assign step_raw = (64'(err_q) >>> kp_shift) + (64'(integ_q) >>> ki_shift);
`else
  logic unused_ki;
  assign unused_ki = ^{ki_shift, clr_integ};
  assign step_raw = 64'(err_q) >>> kp_shift;
`endif
  assign step = (step_raw == 0 && err_q != 0) ? ((err_q < 0) ? -64'sd1 : 64'sd1) : step_raw;
  assign tune_next = TWIDTH'(sat_u($signed(64'(tune)) - step, TWIDTH));
  assign abs_err = DWIDTH'(abs_sat(64'(err_q), DWIDTH));
  assign valid = valid_q;
endmodule

// File: rtl/helppll_ctrl.sv
// helppll_ctrl: helper-PLL acquisition/tracking/lock controller; HELPPLL_CTRL_INTEG_EN adds an integral path
module helppll_ctrl
  import helppll_ctrl_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int TWIDTH      = 16,
  parameter int SETTLE_SAMP = 2,
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_CNT  = 4,
  parameter int RST_GATE    = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DWIDTH-1:0] freqdiff,
  input  logic              stb_freqdiff,
  input  logic [DWIDTH-1:0] gate_coarse,
  input  logic [DWIDTH-1:0] gate_fine,
  input  logic [DWIDTH-1:0] lock_tol,
  input  logic [3:0]        kp_shift,
  input  logic [3:0]        ki_shift,
  input  logic [TWIDTH-1:0] tune_init,
  output logic [DWIDTH-1:0] refcntsamp,
  output logic [TWIDTH-1:0] tune,
  output logic              tune_stb,
  input  logic              tune_ack,
  output logic              locked,
  output logic [2:0]        state,
  output logic [15:0]       lostlock_cnt
);
  localparam logic [7:0] SETTLE = 8'(SETTLE_SAMP);
  localparam logic [7:0] LOCK = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK = 8'(UNLOCK_CNT);
  state_e state_q, state_d;
  logic [TWIDTH-1:0] tune_q, tune_d, tune_next;
  logic [DWIDTH-1:0] refcnt_q, refcnt_d, abs_err, far_tol;
  logic [15:0] lost_q, lost_d;
  logic [7:0] settle_q, settle_d, good_q, good_d, bad_q, bad_d;
  logic tune_stb_q, tune_stb_d, locked_q, locked_d;
  logic accept, valid, clr_integ, correct, in_tol, far;
  assign accept = enable && state_q != IDLE && stb_freqdiff && !tune_stb_q && settle_q == '0 && !valid;
  assign far_tol = DWIDTH'(sat_u($signed(64'(lock_tol)) <<< 3, DWIDTH));
  assign in_tol = abs_err <= lock_tol;
  assign far = abs_err > far_tol;
  helppll_ctrl_step #(.DWIDTH(DWIDTH), .TWIDTH(TWIDTH)) u_step (
    .clk(clk), .reset(reset), .accept(accept), .clr_integ(clr_integ), .freqdiff(freqdiff),
    .kp_shift(kp_shift), .ki_shift(ki_shift), .tune(tune_q), .valid(valid), .abs_err(abs_err),
    .tune_next(tune_next)
  );
  always_comb begin
    state_d = state_q;
    tune_d = tune_q;
    tune_stb_d = tune_stb_q;
    refcnt_d = refcnt_q;
    locked_d = locked_q;
    lost_d = lost_q;
    settle_d = settle_q;
    good_d = good_q;
    bad_d = bad_q;
    clr_integ = 1'b0;
    correct = 1'b0;
    if (state_q == IDLE) begin
      clr_integ = 1'b1;
      if (enable) begin
        state_d = COARSE;
        tune_d = tune_init;
        tune_stb_d = 1'b1;
        refcnt_d = gate_coarse;
        settle_d = SETTLE;
      end
    end else if (!enable) begin
      tune_stb_d = tune_stb_q && !tune_ack;
      if (!tune_stb_q) begin
        state_d = IDLE;
        locked_d = 1'b0;
        refcnt_d = DWIDTH'(RST_GATE);
        settle_d = '0;
        good_d = '0;
        bad_d = '0;
      end
    end else begin
      if (tune_stb_q && tune_ack) begin
        tune_stb_d = 1'b0;
        settle_d = SETTLE;
      end else if (stb_freqdiff && !tune_stb_q && !valid && settle_q != '0) settle_d = settle_q - 8'd1;
      if (valid) begin
        correct = 1'b1;
        if (state_q == COARSE && in_tol) begin
          correct = 1'b0;
          state_d = FINE;
          refcnt_d = gate_fine;
          settle_d = SETTLE;
          good_d = '0;
        end else if (state_q == FINE) begin
          good_d = in_tol ? good_q + 8'd1 : 8'd0;
          if (far) begin
            state_d = COARSE;
            refcnt_d = gate_coarse;
            settle_d = SETTLE;
            good_d = '0;
            clr_integ = 1'b1;
          end else if (good_d == LOCK) begin
            state_d = LOCKED;
            locked_d = 1'b1;
            bad_d = '0;
          end
        end else if (state_q == LOCKED) begin
          bad_d = in_tol ? 8'd0 : bad_q + 8'd1;
          if (bad_d == UNLOCK) begin
            state_d = FINE;
            locked_d = 1'b0;
            good_d = '0;
            bad_d = '0;
            lost_d = lost_q + {15'd0, lost_q != 16'hFFFF};
          end
        end
        if (correct && tune_next != tune_q) begin
          tune_d = tune_next;
          tune_stb_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tune_q <= '0;
      tune_stb_q <= 1'b0;
      refcnt_q <= DWIDTH'(RST_GATE);
      locked_q <= 1'b0;
      lost_q <= '0;
      settle_q <= '0;
      good_q <= '0;
      bad_q <= '0;
    end else begin
      state_q <= state_d;
      tune_q <= tune_d;
      tune_stb_q <= tune_stb_d;
      refcnt_q <= refcnt_d;
      locked_q <= locked_d;
      lost_q <= lost_d;
      settle_q <= settle_d;
      good_q <= good_d;
      bad_q <= bad_d;
    end
  end
  assign refcntsamp = refcnt_q;
  assign tune = tune_q;
  assign tune_stb = tune_stb_q;
  assign locked = locked_q;
  assign state = state_q;
  assign lostlock_cnt = lost_q;
endmodule

// File: tb/tb_helppll_ctrl.sv
// tb_helppll_ctrl: directed plus randomized checks of helppll_ctrl against a per-strobe behavioural model
module tb_helppll_ctrl;
  logic clk = 1'b0;
  logic reset, enable, stb, tune_ack;
  logic [31:0] freqdiff, gate_coarse, gate_fine, lock_tol, refcntsamp;
  logic [3:0] kp_shift, ki_shift;
  logic [15:0] tune_init, tune, lostlock_cnt;
  logic tune_stb, locked;
  logic [2:0] state;
  int vectors = 0, errors = 0;
  int m_state, m_settle, m_good, m_bad, m_locked, m_lost;
  longint m_tune;
  logic [31:0] m_gate;
  bit iss;
  helppll_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .freqdiff(freqdiff), .stb_freqdiff(stb),
    .gate_coarse(gate_coarse), .gate_fine(gate_fine), .lock_tol(lock_tol), .kp_shift(kp_shift),
    .ki_shift(ki_shift), .tune_init(tune_init), .refcntsamp(refcntsamp), .tune(tune),
    .tune_stb(tune_stb), .tune_ack(tune_ack), .locked(locked), .state(state), .lostlock_cnt(lostlock_cnt)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input bit exp_stb);
    chk({tag, "/tune"}, 64'(tune), 64'(m_tune));
    chk({tag, "/tune_stb"}, 64'(tune_stb), 64'(exp_stb));
    chk({tag, "/state"}, 64'(state), 64'(m_state));
    chk({tag, "/locked"}, 64'(locked), 64'(m_locked));
    chk({tag, "/refcntsamp"}, 64'(refcntsamp), 64'(m_gate));
    chk({tag, "/lostlock"}, 64'(lostlock_cnt), 64'(m_lost));
  endtask
  task automatic model(input logic [31:0] fdu, output bit issue);
    longint e, a, st, nt, tol;
    bit corr;
    issue = 0;
    if (m_settle > 0) begin
      m_settle--;
      return;
    end
    e = longint'($signed(fdu));
    tol = longint'(lock_tol);
    a = (e == -64'sd2147483648) ? 64'sd2147483647 : ((e < 0) ? -e : e);
    st = e >>> kp_shift;
    if (st == 0 && e != 0) st = (e < 0) ? -1 : 1;
    nt = m_tune - st;
    if (nt < 0) nt = 0;
    if (nt > 65535) nt = 65535;
    corr = 1;
    if (m_state == 1 && a <= tol) begin
      corr = 0;
      m_state = 2;
      m_gate = gate_fine;
      m_settle = 2;
      m_good = 0;
    end else if (m_state == 2) begin
      m_good = (a <= tol) ? m_good + 1 : 0;
      if (a > 8 * tol) begin
        m_state = 1;
        m_gate = gate_coarse;
        m_settle = 2;
        m_good = 0;
      end else if (m_good == 8) begin
        m_state = 3;
        m_locked = 1;
        m_bad = 0;
      end
    end else if (m_state == 3) begin
      m_bad = (a > tol) ? m_bad + 1 : 0;
      if (m_bad == 4) begin
        m_state = 2;
        m_locked = 0;
        m_good = 0;
        m_bad = 0;
        if (m_lost < 65535) m_lost++;
      end
    end
    if (corr && nt != m_tune) begin
      m_tune = nt;
      issue = 1;
    end
  endtask
  task automatic model_idle();
    m_state = 0;
    m_locked = 0;
    m_gate = 32'd1000;
    m_settle = 0;
    m_good = 0;
    m_bad = 0;
  endtask
  task automatic handshake(input int k);
    for (int i = 0; i < k; i++) begin
      chk("hold_stb", 64'(tune_stb), 64'd1);
      if ($urandom_range(0, 2) == 0) begin
        freqdiff = $urandom;
        stb = 1'b1;
      end
      cyc();
      stb = 1'b0;
    end
    tune_ack = 1'b1;
    stb = 1'($urandom_range(0, 1));
    freqdiff = $urandom;
    cyc();
    tune_ack = 1'b0;
    stb = 1'b0;
    chk("ack_drop", 64'(tune_stb), 64'd0);
    m_settle = 2;
  endtask
  task automatic send(input logic [31:0] fd);
    bit issue;
    freqdiff = fd;
    stb = 1'b1;
    cyc();
    stb = 1'b0;
    chk("early_stb", 64'(tune_stb), 64'd0);
    cyc();
    model(fd, issue);
    chk_all("strobe", issue);
    if (issue) handshake($urandom_range(1, 4));
    repeat ($urandom_range(0, 2)) cyc();
  endtask
  task automatic drain();
    while (m_settle > 0) send($urandom);
  endtask
  function automatic logic [31:0] rnd_fd();
    int t = int'(lock_tol);
    int r = int'($urandom_range(0, 9));
    int v;
    if (r < 8) v = int'($urandom_range(0, 2 * t)) - t;
    else if (r == 8) v = (int'($urandom_range(t + 1, 8 * t)) * ($urandom_range(0, 1) ? 1 : -1));
    else v = int'($urandom);
    return 32'(v);
  endfunction
  initial begin
    logic [31:0] good_vals [8];
    good_vals = '{32'd1, -32'sd1, 32'd2, -32'sd3, 32'd4, 32'd0, -32'sd4, 32'd3};
    reset = 1'b1; enable = 1'b0; stb = 1'b0; tune_ack = 1'b0; freqdiff = '0;
    gate_coarse = 32'd5000; gate_fine = 32'd20000; lock_tol = 32'd4;
    kp_shift = 4'd2; ki_shift = 4'd0; tune_init = 16'h8000;
    m_tune = 0; m_lost = 0;
    model_idle();
    cyc();
    cyc();
    chk_all("reset", 0);
    reset = 1'b0;
    cyc();
    chk_all("idle", 0);
    enable = 1'b1;
    cyc();
    m_state = 1; m_tune = 16'h8000; m_gate = gate_coarse;
    chk_all("enable", 1);
    chk("coarse_gate", 64'(refcntsamp), 64'd5000);
    handshake(3);
    send(32'd7);
    send(32'd7);
    send(32'd400);
    chk("tune_400", 64'(tune), 64'h7F9C);
    send(32'd400);
    send(32'd400);
    chk("settle_hold", 64'(tune), 64'h7F9C);
    send(32'd3);
    chk("to_fine", 64'(state), 64'd2);
    chk("fine_gate", 64'(refcntsamp), 64'd20000);
    drain();
    kp_shift = 4'd4;
    send(32'd1);
    chk("tune_dec1", 64'(tune), 64'h7F9B);
    for (int i = 1; i < 8; i++) begin
      drain();
      send(good_vals[i]);
    end
    chk("lock8", 64'(locked), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drain();
      send(32'd20);
    end
    chk("unlock_locked", 64'(locked), 64'd0);
    chk("unlock_state", 64'(state), 64'd2);
    chk("unlock_cnt", 64'(lostlock_cnt), 64'd1);
    for (int i = 0; i < 8; i++) begin
      drain();
      send(good_vals[i]);
    end
    for (int i = 0; i < 3; i++) begin
      drain();
      send(32'd20);
    end
    drain();
    send(32'd2);
    chk("stay_locked", 64'(state), 64'd3);
    drain();
    enable = 1'b0;
    cyc();
    model_idle();
    chk_all("disable", 0);
    tune_init = 16'h0000;
    kp_shift = 4'd2;
    enable = 1'b1;
    cyc();
    m_state = 1; m_tune = 0; m_gate = gate_coarse;
    chk_all("reenable", 1);
    handshake(2);
    drain();
    send(32'd50);
    chk("floor_tune", 64'(tune), 64'd0);
    send(32'h8000_0000);
    chk("ceil_tune", 64'(tune), 64'hFFFF);
    drain();
    freqdiff = 32'd400;
    stb = 1'b1;
    cyc();
    stb = 1'b0;
    cyc();
    model(32'd400, iss);
    chk_all("pend", iss);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("pend_state", 64'(state), 64'(m_state));
      chk("pend_stb", 64'(tune_stb), 64'd1);
    end
    tune_ack = 1'b1;
    cyc();
    tune_ack = 1'b0;
    chk("pend_ack", 64'(tune_stb), 64'd0);
    cyc();
    model_idle();
    chk_all("disable_pend", 0);
    kp_shift = 4'($urandom_range(0, 6));
    lock_tol = 32'($urandom_range(2, 10));
    tune_init = 16'($urandom);
    enable = 1'b1;
    cyc();
    m_state = 1; m_tune = longint'(tune_init); m_gate = gate_coarse;
    chk_all("rand_start", 1);
    handshake($urandom_range(1, 4));
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 15) == 0) kp_shift = 4'($urandom_range(0, 6));
      send(rnd_fd());
    end
    enable = 1'b0;
    cyc();
    cyc();
    model_idle();
    chk_all("rand_end", 0);
    enable = 1'b1;
    cyc();
    chk("rst_pend", 64'(tune_stb), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    enable = 1'b0;
    model_idle();
    m_tune = 0; m_lost = 0;
    chk_all("rst_mid", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
